mem_array_scanner: RTL and testbench
====================================

// Module: mem_array_scanner
// PURPOSE
//  Upstream address driver and downstream data packer for the 2D bit-memory array (_memArray).
//  On _start it sweeps every (row, column) cell and drives _row/_column into the array.
//  It captures the array's 1-bit _value and packs each row into a word.
//  Each packed row is emitted over a valid/ready handshake, and a running population count is kept.
// PARAMETERS
//  ADDR_W  3  row/column address width; array is 2**ADDR_W x 2**ADDR_W (N = 2**ADDR_W)
//  RD_LAT  1  cycles from address driven to matching _value valid at the clock edge (>=1)
// PORTS
//  _clock      in   1           single clock; all state updates on rising edge
//  _reset      in   1           synchronous, active-high reset
//  _start      in   1           start a full-array scan; sampled only in IDLE
//  _row        out  ADDR_W      row address to array
//  _column     out  ADDR_W      column address to array
//  _value      in   1           array read data, RD_LAT cycles after address
//  _rowData    out  N           packed row: bit c = cell (_rowIndex, c)
//  _rowIndex   out  ADDR_W      row number of _rowData
//  _rowValid   out  1           _rowData/_rowIndex valid
//  _rowReady   in   1           consumer accepts row when _rowValid & _rowReady
//  _busy       out  1           high from start acceptance until _done
//  _done       out  1           one-cycle pulse after last row accepted
//  _onesCount  out  2*ADDR_W+1  count of 1 cells seen in current/last scan (0..N*N)
// BEHAVIOUR
//  Reset (sync, highest priority, any state): FSM=IDLE; every output 0; capture pipeline flushed.
//  States: IDLE, ISSUE, DRAIN, EMIT, DONE.
//  - IDLE: _busy=0. If _start=1: r=0, _onesCount:=0, go ISSUE next cycle.
//  - ISSUE: cycle k=0..N-1 drives _row=r, _column=k. Capture pipeline tags column k.
//    After k=N-1, go DRAIN.
//  - DRAIN: addresses hold their last value. Wait until all N captures are done, then EMIT.
//  - Capture: _value at edge of cycle k+RD_LAT goes into rowbuf[k]; if 1, _onesCount++.
//    Row is complete exactly RD_LAT cycles after its last issue.
//    DRAIN lasts RD_LAT-1 cycles (0 when RD_LAT=1, so ISSUE->EMIT directly at capture).
//  - EMIT: _rowValid=1, _rowData=rowbuf, _rowIndex=r. Both stay stable until the handshake.
//    No new addresses are issued while in EMIT (no overlap between rows).
//    On _rowValid & _rowReady: _rowValid drops next cycle.
//    If r=N-1 go DONE, else r++ and go ISSUE.
//  - DONE: _done=1 for exactly one cycle, _busy=0, then IDLE.
//  - Outside ISSUE, _row/_column hold their last driven value (0 after reset).
//  - _rowData/_rowIndex hold the last emitted row after the handshake.
//  - _onesCount holds its final value until the next accepted _start.
//  _busy=1 in ISSUE/DRAIN/EMIT.
//  _start while busy or in DONE is ignored, never queued.
//  _rowReady held high: one row every N+RD_LAT+1 cycles.
//  _rowReady low: stall indefinitely, with no data loss and no extra reads.
//  _onesCount never wraps: width holds N*N exactly (64 for ADDR_W=3, 7 bits).
//  Reset mid-scan: the scan is aborted, no _done pulse, next _start begins at row 0.
// TESTING
//  1. All-zero array, _rowReady=1, _start pulse -> rows 0..7 each _rowData=8'h00.
//     _done pulses once; _onesCount=0. Start-to-_done = 8*(8+RD_LAT+1)+1 cycles.
//  2. Array with cell(1,5)=1, cell(3,2)=1, cell(6,0)=1 -> row1=8'h20, row3=8'h04, row6=8'h01.
//     All other rows 8'h00; _onesCount=3.
//  3. Checkerboard (cell=r^c&1) with _rowReady low 5 cycles on row 2.
//     -> _rowData=8'hAA held stable with _rowValid=1 for all 5 cycles; _row/_column frozen.
//     Final _onesCount=32.
//  4. _start re-pulsed during row 4 -> no effect; exactly 8 rows and one _done.
//  5. _reset asserted during ISSUE of row 3 -> next cycle all outputs 0, IDLE.
//     New _start scans from row 0 with _onesCount restarting at 0.
//  6. RD_LAT=2 build with all-ones array -> every row 8'hFF, _onesCount=64.
//     Bit alignment is correct, with no bit shifted into the neighbouring column.

Source files
------------

// File: rtl/mem_array_scanner.sv
// Sweeps a 2**ADDR_W x 2**ADDR_W bit array one row at a time and packs each row into a word.
// Each row goes out over valid/ready, and a running count of set cells is kept for the scan.
module mem_array_scanner #(
  parameter int ADDR_W = 3,
  parameter int RD_LAT = 1
) (
  input  logic                   _clock,
  input  logic                   _reset,
  input  logic                   _start,
  output logic [ADDR_W-1:0]      _row,
  output logic [ADDR_W-1:0]      _column,
  input  logic                   _value,
  output logic [2**ADDR_W-1:0]   _rowData,
  output logic [ADDR_W-1:0]      _rowIndex,
  output logic                   _rowValid,
  input  logic                   _rowReady,
  output logic                   _busy,
  output logic                   _done,
  output logic [2*ADDR_W:0]      _onesCount
);

  localparam int N  = 2**ADDR_W;
  localparam int DW = (RD_LAT > 2) ? $clog2(RD_LAT-1) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N-1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_EMIT, S_DONE} state_t;
  state_t state, state_nxt;

  logic                          issue_v;
  logic [RD_LAT:1]               vld_pipe;
  logic [RD_LAT:1][ADDR_W-1:0]   col_pipe;
  logic                          cap_v;
  logic [ADDR_W-1:0]             cap_col;
  logic [N-1:0]                  rowbuf, rowbuf_nxt;
  logic [DW-1:0]                 dcnt;

  assign issue_v = (state == S_ISSUE);
  assign cap_v   = vld_pipe[RD_LAT];
  assign cap_col = col_pipe[RD_LAT];

  // Column tags travel alongside the read so each returning bit lands in its own slot.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      vld_pipe <= '0;
      col_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue_v;
      col_pipe[1] <= _column;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        col_pipe[i] <= col_pipe[i-1];
      end
    end
  end

  always_comb begin
    rowbuf_nxt = rowbuf;
    if (cap_v) rowbuf_nxt[cap_col] = _value;
  end

  always_comb begin
    state_nxt = state;
    _busy     = 1'b0;
    _done     = 1'b0;
    case (state)
      S_IDLE:  if (_start) state_nxt = S_ISSUE;
      S_ISSUE: begin
        _busy = 1'b1;
        if (_column == LAST) state_nxt = (RD_LAT == 1) ? S_EMIT : S_DRAIN;
      end
      S_DRAIN: begin
        _busy = 1'b1;
        if (dcnt == DW'(RD_LAT-2)) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        _busy = 1'b1;
        if (_rowValid && _rowReady) state_nxt = (_row == LAST) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        _done     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state      <= S_IDLE;
      _row       <= '0;
      _column    <= '0;
      _rowData   <= '0;
      _rowIndex  <= '0;
      _rowValid  <= 1'b0;
      _onesCount <= '0;
      rowbuf     <= '0;
      dcnt       <= '0;
    end else begin
      state <= state_nxt;
      if (cap_v) begin
        rowbuf <= rowbuf_nxt;
        if (_value) _onesCount <= _onesCount + 1'b1;
      end
      case (state)
        S_IDLE: if (_start) begin
          _row       <= '0;
          _column    <= '0;
          _onesCount <= '0;
        end
        S_ISSUE: begin
          dcnt <= '0;
          if (_column != LAST) _column <= _column + 1'b1;
        end
        S_DRAIN: dcnt <= dcnt + 1'b1;
        S_EMIT: begin
          // First EMIT cycle is the one where the last bit of the row is captured.
          if (!_rowValid) begin
            _rowValid <= 1'b1;
            _rowData  <= rowbuf_nxt;
            _rowIndex <= _row;
          end else if (_rowReady) begin
            _rowValid <= 1'b0;
            if (_row != LAST) begin
              _row    <= _row + 1'b1;
              _column <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_array_scanner.sv
// Directed bench: two scanners (RD_LAT=1 and RD_LAT=2) against a registered-read bit array model.
module tb_mem_array_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, ready, sel;
  logic [2:0] row1, col1, ri1, row2, col2, ri2;
  logic [7:0] rd1, rd2;
  logic       v1, v2, busy1, busy2, done1, done2;
  logic [6:0] ones1, ones2;
  logic       q1 = 1'b0, q2a = 1'b0, q2b = 1'b0;
  logic [7:0] mem [8];
  logic [7:0] exp_rows [8];
  int         cyc = 0;
  int         n_cmp = 0, n_bad = 0;

  logic [2:0] m_row, m_col, m_ri;
  logic [7:0] m_rd;
  logic       m_valid, m_busy, m_done;
  logic [6:0] m_ones;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    q1  <= mem[row1][col1];
    q2a <= mem[row2][col2];
    q2b <= q2a;
  end

  mem_array_scanner #(.ADDR_W(3), .RD_LAT(1)) u_dut1 (
    ._clock(clk), ._reset(rst), ._start(start & ~sel), ._row(row1), ._column(col1),
    ._value(q1), ._rowData(rd1), ._rowIndex(ri1), ._rowValid(v1), ._rowReady(ready | sel),
    ._busy(busy1), ._done(done1), ._onesCount(ones1));

  mem_array_scanner #(.ADDR_W(3), .RD_LAT(2)) u_dut2 (
    ._clock(clk), ._reset(rst), ._start(start & sel), ._row(row2), ._column(col2),
    ._value(q2b), ._rowData(rd2), ._rowIndex(ri2), ._rowValid(v2), ._rowReady(ready | ~sel),
    ._busy(busy2), ._done(done2), ._onesCount(ones2));

  assign m_row   = sel ? row2  : row1;
  assign m_col   = sel ? col2  : col1;
  assign m_ri    = sel ? ri2   : ri1;
  assign m_rd    = sel ? rd2   : rd1;
  assign m_valid = sel ? v2    : v1;
  assign m_busy  = sel ? busy2 : busy1;
  assign m_done  = sel ? done2 : done1;
  assign m_ones  = sel ? ones2 : ones1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_row"},  m_row, 0);
    chk({tag, "_col"},  m_col, 0);
    chk({tag, "_rd"},   m_rd, 0);
    chk({tag, "_ri"},   m_ri, 0);
    chk({tag, "_vld"},  m_valid, 0);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_ones"}, m_ones, 0);
  endtask

  // One full scan: optional stall on one row, optional stray start during one row.
  task automatic scan(input int exp_ones, input int stall_row, input int stall_n,
                      input int kick_row, input int exp_cyc);
    int nrows = 0, ndone = 0, stalled = 0, cs, cd = -1, tail = -1;
    @(negedge clk);
    chk("idle_busy", m_busy, 0);
    start = 1'b1;
    cs = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if (m_valid && m_ri == stall_row && stalled < stall_n) begin
        ready = 1'b0;
        stalled++;
        chk("stall_data", m_rd, exp_rows[stall_row]);
        chk("stall_row", m_row, stall_row);
        chk("stall_col", m_col, 7);
      end else begin
        ready = 1'b1;
      end
      if (m_valid && ready) begin
        chk("row_idx", m_ri, nrows);
        chk("row_data", m_rd, exp_rows[m_ri]);
        if (nrows == 0) chk("busy_mid", m_busy, 1);
        nrows++;
      end
      start = (m_valid && m_ri == kick_row);
      if (m_done) begin
        ndone++;
        if (cd < 0) begin
          cd = cyc;
          chk("done_busy", m_busy, 0);
          chk("ones", m_ones, exp_ones);
          chk("latency", cd - cs, exp_cyc);
          tail = 20;
        end
      end
      if (tail == 0) break;
      if (tail > 0) tail--;
      @(negedge clk);
    end
    ready = 1'b1;
    start = 1'b0;
    if (cd < 0) chk("timeout", 0, 1);
    chk("rows", nrows, 8);
    chk("dones", ndone, 1);
    chk("ones_hold", m_ones, exp_ones);
  endtask

  task automatic set_checker();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem[r][c] = ((r ^ c) & 1) != 0;
    for (int r = 0; r < 8; r++) exp_rows[r] = r[0] ? 8'h55 : 8'hAA;
  endtask

  initial begin
    int found;
    rst = 1'b1; start = 1'b0; ready = 1'b1; sel = 1'b0;
    for (int r = 0; r < 8; r++) begin mem[r] = 8'h00; exp_rows[r] = 8'h00; end
    repeat (3) @(negedge clk);
    chk_zero("rst1");
    sel = 1'b1;
    chk_zero("rst2");
    sel = 1'b0;
    rst = 1'b0;

    // all-zero array
    scan(0, -1, 0, -1, 81);

    // three isolated set cells
    mem[1] = 8'h20; mem[3] = 8'h04; mem[6] = 8'h01;
    exp_rows[1] = 8'h20; exp_rows[3] = 8'h04; exp_rows[6] = 8'h01;
    scan(3, -1, 0, -1, 81);

    // checkerboard, consumer stalls 5 cycles on row 2
    set_checker();
    scan(32, 2, 5, -1, 86);

    // stray start during row 4 is ignored
    scan(32, -1, 0, 4, 81);

    // reset during ISSUE of row 3
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int t = 0; t < 200; t++) begin
      if (m_row == 3 && m_col == 2 && m_busy) begin found = 1; break; end
      @(negedge clk);
    end
    chk("rst_reach", found, 1);
    chk("pre_rst_ones", m_ones, 13);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    found = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (m_done || m_busy) found = 1;
    end
    chk("post_rst_idle", found, 0);
    scan(32, -1, 0, -1, 81);

    // RD_LAT=2 instance, all-ones array
    sel = 1'b1;
    for (int r = 0; r < 8; r++) begin mem[r] = 8'hFF; exp_rows[r] = 8'hFF; end
    scan(64, -1, 0, -1, 89);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
